// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, optional parity, 1 stop bit, 16x oversampled.
// Latency: 2-clk synchronizer, then mid-bit sampling; rx_valid follows the stop sample by one clk, with no backpressure.
module uart_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       rx,
    input  logic [1:0] parity_mode,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic       rx_meta_q, rx_meta_d;
    logic       rx_s_q, rx_s_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] mode_q, mode_d;
    logic       par_bad_q, par_bad_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;
    logic       rx_busy_q, rx_busy_d;

    always_comb begin
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        mode_d       = mode_q;
        par_bad_d    = par_bad_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_busy_d    = rx_busy_q;

        if (sample_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        cnt_d   = 4'd0;
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_q == 4'd7) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d     = 4'd0;
                            mode_d    = parity_mode;
                            idx_d     = 3'd0;
                            par_bad_d = 1'b0;
                            rx_busy_d = 1'b1;
                            state_d   = DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        shift_d[idx_q] = rx_s_q;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = (mode_q == 2'b00) ? STOP : PARITY;
                        end
                    end
                end
                PARITY: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        case (mode_q)
                            2'b01:   par_bad_d = (rx_s_q != (^shift_q));
                            2'b10:   par_bad_d = (rx_s_q != (~^shift_q));
                            default: par_bad_d = 1'b0;
                        endcase
                        state_d = STOP;
                    end
                end
                STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        rx_data_d    = shift_q;
                        parity_err_d = par_bad_q;
                        frame_err_d  = ~rx_s_q;
                        rx_valid_d   = 1'b1;
                        rx_busy_d    = 1'b0;
                        state_d      = rx_s_q ? IDLE : BRK_WAIT;
                    end
                end
                BRK_WAIT: begin
                    // A line held low after a bad stop bit must not look like a new start.
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            mode_q       <= 2'b00;
            par_bad_q    <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            mode_q       <= mode_d;
            par_bad_q    <= par_bad_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = rx_busy_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have no parameters; the frame format is fixed at 1 start bit, 8 data bits LSB-first, an optional parity bit, and 1 stop bit, sampled at 16x oversampling.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sample_tick  input  1  one-clk pulse at 16x the baud rate; all bit timing counts these pulses.
REQ-005 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 parity_mode  input  2  00 none, 01 even, 10 odd, 11 parity slot present but not checked.
REQ-007 rx_data  output  8  last received byte.
REQ-008 rx_valid  output  1  one-clk pulse marking a completed frame.
REQ-009 parity_err  output  1  parity mismatch flag for the last frame.
REQ-010 frame_err  output  1  stop bit sampled low in the last frame.
REQ-011 rx_busy  output  1  high from verified start bit until frame end.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value (rx_s).
REQ-013 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP and BRK_WAIT, plus a 4-bit tick counter and a 3-bit bit index.
REQ-014 The FSM and counter SHALL advance only on clk edges where sample_tick=1; the exception is rx_valid generation (REQ-021).
REQ-015 IDLE: on a tick with rx_s=0, the block SHALL clear the counter and go to START.
REQ-016 START: on the 8th tick (counter=7), the block SHALL check rx_s.
- rx_s=1: false start; return to IDLE, no outputs change.
- rx_s=0: clear the counter, latch parity_mode, clear the bit index, set rx_busy=1, go to DATA.
REQ-017 DATA: on every 16th tick (counter wraps 15->0), the block SHALL shift rx_s into bit[index], LSB first.
- After bit 7, go to STOP if the latched mode is 00, else go to PARITY.
REQ-018 PARITY: on the 16th tick, the block SHALL sample the parity bit and compare it with the expected value.
- Expected value: ^data for even, ~^data for odd; mode 11 expects nothing and never sets an error.
- Go to STOP.
REQ-019 STOP: on the 16th tick, the block SHALL sample the stop bit.
- Update rx_data, parity_err and frame_err (frame_err = ~stop sample).
- Request rx_valid and clear rx_busy.
- Go to IDLE if stop=1, or to BRK_WAIT if stop=0.
REQ-020 BRK_WAIT: the block SHALL stay in this state until a tick with rx_s=1, then go to IDLE; no new frame may start while the line is held low.
REQ-021 rx_valid SHALL be high for exactly one clk cycle, the cycle after the stop-sampling edge, even when sample_tick is asserted continuously.
REQ-022 rx_valid SHALL be asserted for frames with errors as well; the error flags are valid in that cycle.
REQ-023 rx_data, parity_err and frame_err SHALL hold their values until the next frame completes; a false start SHALL leave them unchanged.
REQ-024 Changes to parity_mode during a frame SHALL NOT affect that frame.
REQ-025 Line latency SHALL be 2 clk (synchronizer) plus tick-quantized sampling at mid-bit (8+16n ticks after the detected falling edge).

Reset
REQ-026 On reset, the block SHALL enter IDLE and clear the counter and bit index.
REQ-027 On reset, the synchronizer flops SHALL be set to 1.
REQ-028 On reset, the outputs SHALL be rx_data=0x00, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte with no rx_valid pulse; reception resumes on the next falling edge after release.

Verification
REQ-030 Mode 00, byte 0xA5, stop=1 -> rx_data=0xA5, rx_valid one cycle, parity_err=0, frame_err=0.
REQ-031 Mode 01, byte 0x3C with parity bit 1 -> rx_data=0x3C, parity_err=1; then byte 0x3C with parity bit 0 -> parity_err=0.
REQ-032 Mode 10, byte 0x01 with parity bit 0 -> parity_err=0; mode 11, byte 0x01 with parity bit 1 -> parity_err=0.
REQ-033 Low glitch of 4 ticks on rx -> no rx_busy, no rx_valid; a following 0x5A frame is received correctly.
REQ-034 Byte 0xFF with stop=0 and the line held low for 40 ticks -> frame_err=1 and rx_valid pulse; no new frame until rx returns high; the next 0x81 frame is received with frame_err=0.
REQ-035 Reset asserted after data bit 3 of a frame -> outputs at reset values, no rx_valid; a following 0xC3 frame is received correctly.
